// File: rtl/alu_op_decode_stage.sv
// alu_op_decode_stage: RV32I/M ALU-op decode buffered in a DEPTH-entry valid/ready FIFO
module alu_op_decode_stage #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter int SUPPORT_M = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_alu_op,
  output logic            out_src_b_imm,
  output logic            out_illegal,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc
);
  localparam int cw = $clog2(DEPTH + 1);
  localparam int pw = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [cw-1:0] count, next_count;
  logic [pw-1:0] wptr, rptr;
  logic [4:0] op_mem [DEPTH];
  logic imm_mem [DEPTH];
  logic ill_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic push, pop, d_imm, d_ill;
  logic [4:0] d_op;
  logic [2:0] f3;
  logic [6:0] f7, opc;
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];
  assign opc = in_inst[6:0];
  always_comb begin
    d_op = 5'd0;
    d_imm = 1'b0;
    d_ill = 1'b0;
    case (opc)
      7'b0010011: begin
        d_ill = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
        d_op = {1'b0, f3 == 3'b101 && in_inst[30], f3};
        d_imm = 1'b1;
      end
      7'b0110011: begin
        d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || (f7 == 7'h01 && SUPPORT_M != 0));
        d_op = {f7 == 7'h01, f7 != 7'h00, f3};
      end
      7'b1100011: begin
        d_ill = f3[2:1] == 2'b01;
        d_op = {2'b10, f3};
      end
      7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111: d_imm = 1'b1;
      7'b1100111: begin
        d_ill = f3 != 3'b000;
        d_imm = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_op = 5'd0;
      d_imm = 1'b0;
    end
  end
  function automatic logic [pw-1:0] inc(input logic [pw-1:0] p);
    return p == pw'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign push = in_valid && in_ready;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign next_count = count + cw'(push) - cw'(pop);
  assign out_alu_op = out_valid ? op_mem[rptr] : '0;
  assign out_src_b_imm = out_valid ? imm_mem[rptr] : 1'b0;
  assign out_illegal = out_valid ? ill_mem[rptr] : 1'b0;
  assign out_inst = out_valid ? inst_mem[rptr] : '0;
  assign out_pc = out_valid ? pc_mem[rptr] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      in_ready <= 1'b0;
    end else if (flush) begin
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      in_ready <= 1'b1;
    end else begin
      count <= next_count;
      in_ready <= next_count < cw'(DEPTH);
      if (push) wptr <= inc(wptr);
      if (pop) rptr <= inc(rptr);
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      op_mem[wptr] <= d_op;
      imm_mem[wptr] <= d_imm;
      ill_mem[wptr] <= d_ill;
      inst_mem[wptr] <= in_inst;
      pc_mem[wptr] <= in_pc;
    end
  end
endmodule

// File: tb/tb_alu_op_decode_stage.sv
// tb_alu_op_decode_stage: four differently parametrised instances checked against a queue-based model
module tb_alu_op_decode_stage;
  typedef struct packed {
    logic [4:0] op;
    logic imm;
    logic ill;
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  localparam int n = 4;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic in_ready [n];
  logic out_valid [n];
  logic [4:0] out_alu_op [n];
  logic out_src_b_imm [n];
  logic out_illegal [n];
  logic [31:0] out_inst [n];
  logic [31:0] out_pc [n];
  int dep [n] = '{2, 2, 1, 4};
  bit sm [n] = '{1'b1, 1'b0, 1'b1, 1'b1};
  ent_t mq [n][$];
  bit mrdy [n];
  bit started = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < n; g++) begin : g_dut
    alu_op_decode_stage #(
      .XLEN(32),
      .DEPTH(g == 2 ? 1 : g == 3 ? 4 : 2),
      .SUPPORT_M(g == 1 ? 0 : 1)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready[g]),
      .in_inst(in_inst),
      .in_pc(in_pc),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .out_alu_op(out_alu_op[g]),
      .out_src_b_imm(out_src_b_imm[g]),
      .out_illegal(out_illegal[g]),
      .out_inst(out_inst[g]),
      .out_pc(out_pc[g])
    );
  end
  function automatic ent_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input bit m_en);
    int f3 = int'(i[14:12]);
    int f7 = int'(i[31:25]);
    int m = 0;
    int s = 0;
    bit ok = 1'b0;
    bit imm = 1'b0;
    bit plain_add = 1'b0;
    ent_t e;
    case (int'(i[6:0]))
      'h13: begin
        imm = 1'b1;
        ok = f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 32) : 1'b1;
        s = (f3 == 5 && f7 == 32) ? 1 : 0;
      end
      'h33: begin
        ok = f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) || (f7 == 1 && m_en);
        s = f7 != 0 ? 1 : 0;
        m = f7 == 1 ? 1 : 0;
      end
      'h63: begin
        ok = f3 != 2 && f3 != 3;
        m = 1;
      end
      'h03, 'h23, 'h37, 'h17, 'h6f: begin
        ok = 1'b1;
        imm = 1'b1;
        plain_add = 1'b1;
      end
      'h67: begin
        ok = f3 == 0;
        imm = 1'b1;
        plain_add = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    e.op = (!ok || plain_add) ? 5'd0 : 5'(m * 16 + s * 8 + f3);
    e.imm = ok && imm;
    e.ill = !ok;
    e.inst = i;
    e.pc = pc;
    return e;
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < n; k++) begin
      if (!rst_n) begin
        started = 1'b1;
        mq[k].delete();
        mrdy[k] = 1'b0;
      end else if (flush) begin
        mq[k].delete();
        mrdy[k] = 1'b1;
      end else begin
        bit pu = in_valid && mrdy[k];
        if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
        if (pu) mq[k].push_back(ref_dec(in_inst, in_pc, sm[k]));
        mrdy[k] = mq[k].size() < dep[k];
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < n; k++) begin
        ent_t e = mq[k].size() > 0 ? mq[k][0] : '0;
        logic [72:0] got = {out_valid[k], in_ready[k], out_alu_op[k], out_src_b_imm[k], out_illegal[k], out_inst[k], out_pc[k]};
        logic [72:0] exp = {mq[k].size() > 0, mrdy[k], e};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL model k=%0d t=%0t got v%b r%b op%b imm%b ill%b inst%h pc%h required v%b r%b op%b imm%b ill%b inst%h pc%h",
                   k, $time, got[72], got[71], got[70:66], got[65], got[64], got[63:32], got[31:0],
                   exp[72], exp[71], exp[70:66], exp[65], exp[64], exp[63:32], exp[31:0]);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [31:0] i);
    in_valid = 1'b1;
    in_inst = i;
    in_pc = $urandom;
    cyc();
    in_valid = 1'b0;
  endtask
  task automatic chk_head(input string name, input int k, input logic [4:0] op, input logic imm, input logic ill);
    chk({name, "_valid"}, 32'(out_valid[k]), 32'd1);
    chk({name, "_op"}, 32'(out_alu_op[k]), 32'(op));
    chk({name, "_imm"}, 32'(out_src_b_imm[k]), 32'(imm));
    chk({name, "_ill"}, 32'(out_illegal[k]), 32'(ill));
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [6:0] tab [10] = '{7'h13, 7'h33, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h0b};
    logic [31:0] w = $urandom;
    w[6:0] = tab[$urandom_range(9)];
    case ($urandom_range(3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction
  initial begin
    ent_t e;
    e = ref_dec(32'h40B50533, 32'h0, 1'b1);
    chk("pin_sub", 32'(e.op), 32'h08);
    e = ref_dec(32'h4020D093, 32'h0, 1'b1);
    chk("pin_srai", 32'({e.op, e.imm}), 32'({5'b01101, 1'b1}));
    e = ref_dec(32'h02B50533, 32'h0, 1'b0);
    chk("pin_mul_nom", 32'({e.op, e.ill}), 32'({5'b00000, 1'b1}));
    e = ref_dec(32'h00B52463, 32'h0, 1'b1);
    chk("pin_br010", 32'(e.ill), 32'd1);
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_inst = '0;
    in_pc = '0;
    cyc();
    cyc();
    chk("rst_ready", 32'(in_ready[0]), 32'd0);
    chk("rst_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_inst", out_inst[0], 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("ready_after_rst", 32'(in_ready[0]), 32'd1);
    out_ready = 1'b1;
    push1(32'h00A28293);
    chk_head("addi", 0, 5'b00000, 1'b1, 1'b0);
    push1(32'h40B50533);
    chk_head("sub", 0, 5'b01000, 1'b0, 1'b0);
    push1(32'h4020D093);
    chk_head("srai", 0, 5'b01101, 1'b1, 1'b0);
    push1(32'h02B50533);
    chk_head("mul", 0, 5'b11000, 1'b0, 1'b0);
    chk_head("mul_nom", 1, 5'b00000, 1'b0, 1'b1);
    chk("mul_nom_inst", out_inst[1], 32'h02B50533);
    push1(32'h00B51463);
    chk_head("bne", 0, 5'b10001, 1'b0, 1'b0);
    push1(32'h00B52463);
    chk_head("br010", 0, 5'b00000, 1'b0, 1'b1);
    cyc();
    cyc();
    out_ready = 1'b0;
    push1(32'h00100093);
    chk("bp_ready1", 32'(in_ready[0]), 32'd1);
    push1(32'h00200113);
    chk("bp_ready2", 32'(in_ready[0]), 32'd0);
    in_valid = 1'b1;
    in_inst = 32'h00300193;
    cyc();
    cyc();
    chk("bp_held_ready", 32'(in_ready[0]), 32'd0);
    chk("bp_head", out_inst[0], 32'h00100093);
    out_ready = 1'b1;
    cyc();
    chk("drain1", out_inst[0], 32'h00200113);
    cyc();
    in_valid = 1'b0;
    chk("drain2", out_inst[0], 32'h00300193);
    cyc();
    chk("drain_empty", 32'(out_valid[0]), 32'd0);
    out_ready = 1'b0;
    push1(32'h00100093);
    push1(32'h00200113);
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_inst = 32'h00400213;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid[0]), 32'd0);
    chk("flush_ready", 32'(in_ready[0]), 32'd1);
    cyc();
    chk("flush_dropped", 32'(out_valid[0]), 32'd0);
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(3) != 0;
      in_inst = rnd_inst();
      in_pc = $urandom;
      out_ready = $urandom_range(2) != 0;
      flush = $urandom_range(40) == 0;
      cyc();
    end
    flush = 1'b1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk("rst_over_flush", 32'(in_ready[0]), 32'd0);
    rst_n = 1'b1;
    flush = 1'b0;
    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
